// File: rtl/trng_fetch.sv
// Consumer side of the TRNG gen/rdy/rdn handshake: fetches words into a small FIFO
// and serves them on a req/ack read port. Optional repetition test: TRNG_FETCH_RCT_EN.
module trng_fetch #(
   parameter int W       = 32,
   parameter int DEPTH   = 4,
   parameter int DISCARD = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       trn_gen,
   input  logic                       trn_rdy,
   input  logic [W-1:0]               trn_rdn,
   input  logic                       rd_req,
   output logic                       rd_ack,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH):0]     fifo_cnt,
   output logic                       rct_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   localparam logic [3:0] DISC_INIT = 4'(DISCARD);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    disc_q, disc_d;
   logic          rd_ack_q, rd_ack_d;
   logic [W-1:0]  rd_data_q, rd_data_d;
   logic [W-1:0]  mem_q [DEPTH];

   logic capture;
   logic repeat_hit;
   logic push;
   logic pop;

   // Handshake: a word is taken only on trn_rdy while in REQ; rd_req is a level held
   // until the one-cycle rd_ack, which is never asserted on two consecutive cycles.
   always_comb begin
      capture = (state_q == REQ) && trn_rdy;
      pop     = rd_req && (cnt_q != '0) && !rd_ack_q;
   end

`ifdef TRNG_FETCH_RCT_EN
   logic [W-1:0] prev_q, prev_d;
   logic         have_prev_q, have_prev_d;
   logic         rct_err_q, rct_err_d;

   always_comb begin
      repeat_hit  = capture && have_prev_q && (trn_rdn == prev_q);
      prev_d      = capture ? trn_rdn : prev_q;
      have_prev_d = have_prev_q | capture;
      rct_err_d   = rct_err_q | repeat_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         rct_err_q   <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         rct_err_q   <= rct_err_d;
      end
   end

   assign rct_err = rct_err_q;
`else
   assign repeat_hit = 1'b0;
   assign rct_err    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      disc_d    = disc_q;
      rd_ack_d  = pop;
      rd_data_d = rd_data_q;
      push      = 1'b0;

      // Discarded words still pass through the repetition test above.
      if (capture) begin
         if (disc_q != 4'd0) begin
            disc_d = disc_q - 4'd1;
         end else if (!repeat_hit) begin
            push = 1'b1;
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      case (state_q)
         IDLE: begin
            // Space is judged after this cycle's pop so a read frees a slot immediately.
            if ((cnt_q - CW'(pop)) < CW'(DEPTH)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (trn_rdy) begin
               state_d = DROP;
            end
         end
         DROP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         disc_q    <= DISC_INIT;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         disc_q    <= disc_d;
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= trn_rdn;
      end
   end

   // The fetch FSM only requests with a free slot, so a push into a full FIFO is a bug.
   assert property (@(posedge clk) disable iff (rst) !(push && (cnt_q == CW'(DEPTH))));

   assign trn_gen  = (state_q == REQ);
   assign rd_ack   = rd_ack_q;
   assign rd_data  = rd_data_q;
   assign fifo_cnt = cnt_q;

endmodule
